// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Pipeline stage register with valid/ready handshake, 2-entry
//               skid buffer, freeze (cpu_en), flush and optional performance
//               counters enabled by the PIPE_STAGE_PERF_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // in_ready depends only on registered state (and reset), never on out_ready.
    assign in_ready  = (r_state != ST_FULL) && !rst;
    assign out_valid = (r_state != ST_EMPTY);
    assign occupancy = r_state;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;

    assign w_push  = in_valid && in_ready && cpu_en;
    assign w_pop   = out_valid && out_ready && cpu_en;
    assign w_flush = flush && cpu_en;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (w_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush) begin
                // Payload is kept; only control is killed.
                r_main_ctrl <= '0;
                r_skid_ctrl <= '0;
            end else begin
                if (w_load_main_in) begin
                    r_main_ctrl <= in_ctrl;
                    r_main_data <= in_data;
                end else if (w_load_main_skid) begin
                    r_main_ctrl <= r_skid_ctrl;
                    r_main_data <= r_skid_data;
                end
                if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (cpu_en) begin
            if (out_valid && !out_ready && !flush && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!out_valid && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// Testbench for pipe_stage_buf: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst, cpu_en, flush, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [95:0] in_data;
    logic        in_ready, out_valid;
    logic [7:0]  out_ctrl;
    logic [95:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        s_in_ready, s_out_valid;
    logic [1:0]  s_out_ctrl;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy, s_stall_cnt, s_bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Narrow instance sharing the stimulus, used for counter saturation.
    pipe_stage_buf #(.DATA_W(8), .CTRL_W(2), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl[1:0]), .in_data(in_data[7:0]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic [7:0]  c;
        logic [95:0] d;
    } ent_t;

    ent_t q[$];
    int   m_stall, m_bubble;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare every DUT output against the model as of now.
    task automatic check_model();
        int exp_stall, exp_bubble, exp_s_stall, exp_s_bubble;
`ifdef PIPE_STAGE_PERF_EN
        exp_stall    = sat(m_stall, 65535);
        exp_bubble   = sat(m_bubble, 65535);
        exp_s_stall  = sat(m_stall, 3);
        exp_s_bubble = sat(m_bubble, 3);
`else
        exp_stall = 0; exp_bubble = 0; exp_s_stall = 0; exp_s_bubble = 0;
`endif
        chk("m_out_valid", out_valid, q.size() > 0);
        chk("m_occupancy", occupancy, q.size());
        chk("m_in_ready", in_ready, !rst && q.size() < 2);
        chk("m_out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : 8'h00);
        if (q.size() > 0) chk("m_out_data", out_data, q[0].d);
        chk("m_stall_cnt", stall_cnt, exp_stall);
        chk("m_bubble_cnt", bubble_cnt, exp_bubble);
        chk("m_small_stall", s_stall_cnt, exp_s_stall);
        chk("m_small_bubble", s_bubble_cnt, exp_s_bubble);
    endtask

    // Apply one cycle of inputs, advance the model, clock, then compare.
    task automatic cyc(input logic r, input logic en, input logic fl, input logic iv,
                       input logic [7:0] c, input logic [95:0] d, input logic ordy);
        int   sz;
        ent_t e;
        rst = r; cpu_en = en; flush = fl; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
        sz = q.size();
        if (r) begin
            q.delete(); m_stall = 0; m_bubble = 0;
        end else if (en) begin
            if (sz == 0) m_bubble++;
            if (fl) begin
                q.delete();
            end else begin
                if (sz > 0 && !ordy) m_stall++;
                if (sz > 0 && ordy) void'(q.pop_front());
                if (iv && sz < 2) begin
                    e.c = c; e.d = d; q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        iv, ordy, en, fl;
        logic [7:0]  c;
        logic [31:0] d;
        logic [1:0]  x_occ;
        logic        x_ov, x_ir;
        logic [7:0]  x_ctrl;
        logic        chk_d;
        logic [31:0] x_d;
    } vec_t;

    vec_t tbl[11];
    logic [1:0]  frz_occ;
    logic [95:0] frz_data;

    initial begin
        // iv ordy en fl ctrl data | occ ov ir ctrl chk_d data
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 32'h11, 2'd1, 1'b1, 1'b1, 8'h01, 1'b1, 32'h11};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 32'h22, 2'd2, 1'b1, 1'b0, 8'h01, 1'b1, 32'h11};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 32'h33, 2'd2, 1'b1, 1'b0, 8'h01, 1'b1, 32'h11};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00, 2'd1, 1'b1, 1'b1, 8'h02, 1'b1, 32'h22};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 32'h44, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 32'h44, 2'd1, 1'b1, 1'b1, 8'hFF, 1'b1, 32'h44};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 32'h55, 2'd2, 1'b1, 1'b0, 8'hFF, 1'b1, 32'h44};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 32'h66, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 32'h77, 2'd1, 1'b1, 1'b1, 8'h05, 1'b1, 32'h77};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00};

        q.delete(); m_stall = 0; m_bubble = 0;
        rst = 1'b1; cpu_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready_low", in_ready, 1'b0);
        cyc(1, 0, 0, 0, 8'h0, '0, 0);
        cyc(1, 1, 1, 1, 8'hAA, 96'h5, 1);
        chk("rst_out_data", out_data, 96'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        cyc(0, 1, 0, 0, 8'h0, '0, 0);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            cyc(0, tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].c, {64'h0, tbl[i].d}, tbl[i].ordy);
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].x_occ);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].x_ov);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].x_ir);
            chk($sformatf("tbl%0d_out_ctrl", i), out_ctrl, tbl[i].x_ctrl);
            if (tbl[i].chk_d) chk($sformatf("tbl%0d_out_data", i), out_data, {64'h0, tbl[i].x_d});
        end

        // Stream 1..8 with a 5-cycle freeze after the 4th entry
        cyc(1, 1, 0, 0, 8'h0, '0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 1, 8'h10 + 8'(i), 96'(i), 1);
            chk("stream_data", out_data, 96'(i));
            chk("stream_occ", occupancy, 2'd1);
            if (i == 4) begin
                frz_occ = occupancy; frz_data = out_data;
                for (int k = 0; k < 5; k++) begin
                    cyc(0, 0, 0, 1, 8'hEE, 96'h99, 1);
                    chk("freeze_occ", occupancy, frz_occ);
                    chk("freeze_data", out_data, frz_data);
                end
            end
        end
        cyc(0, 1, 0, 0, 8'h0, '0, 1);
        chk("stream_drained", out_valid, 1'b0);

        // Reset while FULL
        cyc(0, 1, 0, 1, 8'hC1, 96'hA, 0);
        cyc(0, 1, 0, 1, 8'hC2, 96'hB, 0);
        chk("full_occ", occupancy, 2'd2);
        rst = 1'b1; #1;
        chk("rst_full_in_ready", in_ready, 1'b0);
        cyc(1, 1, 0, 1, 8'hC3, 96'hC, 1);
        chk("rst_full_occ", occupancy, 2'd0);
        chk("rst_full_data", out_data, 96'h0);
        chk("rst_full_ctrl", out_ctrl, 8'h0);
        cyc(0, 1, 0, 0, 8'h0, '0, 0);
        chk("rst_full_in_ready_after", in_ready, 1'b1);

        // Performance counters: 3 stall cycles and 4 bubble cycles
        cyc(1, 1, 0, 0, 8'h0, '0, 0);
        cyc(0, 1, 0, 1, 8'h01, 96'h1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 8'h0, '0, 0);
        cyc(0, 1, 0, 0, 8'h0, '0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 8'h0, '0, 1);
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall", stall_cnt, 16'd3);
        chk("perf_bubble", bubble_cnt, 16'd4);
        chk("perf_small_bubble_sat", s_bubble_cnt, 2'd3);
`else
        chk("perf_stall_off", stall_cnt, 16'd0);
        chk("perf_bubble_off", bubble_cnt, 16'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 19) == 0,
                1'($urandom),
                8'($urandom),
                {$urandom, $urandom, $urandom},
                $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
